// File: rtl/priority_enc_pkg.sv
// Shared types and helpers for the priority scan encoder.
// Holds the scan FSM state type and the index-width helper.
package priority_enc_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_e;

   // Index width for a vector; never narrower than one bit.
   function automatic int idx_w(input int width);
      int r;
      r = $clog2(width);
      if (r < 1) begin
         return 1;
      end else begin
         return r;
      end
   endfunction

endpackage

// File: rtl/priority_find_first.sv
// Combinational find-first over a request vector.
// Reports the priority index, an any-set flag and an exactly-one-set flag.
module priority_find_first #(
   parameter int WIDTH     = 16,
   parameter int MSB_FIRST = 1,
   parameter int IDX_W     = 4
) (
   input  logic [WIDTH-1:0] vec_i,
   output logic [IDX_W-1:0] index_o,
   output logic             any_o,
   output logic             single_o
);

   localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

   // Later hits overwrite earlier ones, so the scan direction sets the winner.
   always_comb begin
      index_o = '0;
      if (MSB_FIRST != 0) begin
         for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
               index_o = IDX_W'(i);
            end else begin
               index_o = index_o;
            end
         end
      end else begin
         for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
               index_o = IDX_W'(i);
            end else begin
               index_o = index_o;
            end
         end
      end
   end

   assign any_o    = |vec_i;
   assign single_o = ((vec_i & (vec_i - ONE)) == '0) && any_o;

endmodule

// File: rtl/priority_scan_encoder.sv
// Accepts a request vector and emits the index of each set bit, one beat
// per cycle in priority order; an all-zero vector yields a single "none" beat.
module priority_scan_encoder
   import priority_enc_pkg::*;
#(
   parameter  int WIDTH     = 16,
   parameter  int MSB_FIRST = 1,
   localparam int IDX_W     = idx_w(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             flush,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_last,
   output logic             out_none,
   output logic             busy
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] work_q, work_d;
   logic [IDX_W-1:0] ff_index;
   logic             ff_any;
   logic             ff_single;

   priority_find_first #(
      .WIDTH     (WIDTH),
      .MSB_FIRST (MSB_FIRST),
      .IDX_W     (IDX_W)
   ) u_find (
      .vec_i    (work_q),
      .index_o  (ff_index),
      .any_o    (ff_any),
      .single_o (ff_single)
   );

   // Outputs depend only on registered state, never on in_data.
   assign in_ready  = (state_q == IDLE);
   assign busy      = !in_ready;
   assign out_valid = (state_q == EMIT);
   assign out_index = out_valid ? ff_index : '0;
   assign out_none  = out_valid && !ff_any;
   assign out_last  = out_valid && (ff_single || !ff_any);

   // Next-state: flush wins over both handshakes.
   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      case (state_q)
         IDLE: begin
            if (flush) begin
               work_d = '0;
            end else if (in_valid) begin
               work_d  = in_data;
               state_d = EMIT;
            end else begin
               state_d = IDLE;
            end
         end
         EMIT: begin
            if (flush) begin
               work_d  = '0;
               state_d = IDLE;
            end else if (out_ready) begin
               work_d[ff_index] = 1'b0;
               if (out_last) begin
                  state_d = IDLE;
               end else begin
                  state_d = EMIT;
               end
            end else begin
               state_d = EMIT;
            end
         end
         default: begin
            work_d  = '0;
            state_d = IDLE;
         end
      endcase
   end

   // State and working vector registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         work_q  <= '0;
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
      end
   end

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Randomised self-checking bench: three encoder configurations checked
// against a queue-based model of the expected beat sequence.
module tb_priority_scan_encoder;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        iv, fl, ordy;
   logic [15:0] idata;
   int          sel;

   logic        a_ir, a_ov, a_ol, a_on, a_bsy;
   logic [3:0]  a_idx;
   logic        b_ir, b_ov, b_ol, b_on, b_bsy;
   logic [3:0]  b_idx;
   logic        c_ir, c_ov, c_ol, c_on, c_bsy;
   logic [2:0]  c_idx;

   logic        ir, ov, ol, on_, bsy;
   logic [3:0]  idx;

   int tests_run = 0;
   int tests_failed = 0;
   int exp_q[$];
   bit exp_none;

   always #5 clk = ~clk;

   priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(1)) u_a (
      .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 0), .in_ready(a_ir),
      .in_data(idata), .flush(fl && sel == 0), .out_valid(a_ov), .out_ready(ordy && sel == 0),
      .out_index(a_idx), .out_last(a_ol), .out_none(a_on), .busy(a_bsy));

   priority_scan_encoder #(.WIDTH(16), .MSB_FIRST(0)) u_b (
      .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 1), .in_ready(b_ir),
      .in_data(idata), .flush(fl && sel == 1), .out_valid(b_ov), .out_ready(ordy && sel == 1),
      .out_index(b_idx), .out_last(b_ol), .out_none(b_on), .busy(b_bsy));

   priority_scan_encoder #(.WIDTH(5), .MSB_FIRST(1)) u_c (
      .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2), .in_ready(c_ir),
      .in_data(idata[4:0]), .flush(fl && sel == 2), .out_valid(c_ov), .out_ready(ordy && sel == 2),
      .out_index(c_idx), .out_last(c_ol), .out_none(c_on), .busy(c_bsy));

   always_comb begin
      case (sel)
         0: begin ir = a_ir; ov = a_ov; ol = a_ol; on_ = a_on; bsy = a_bsy; idx = a_idx; end
         1: begin ir = b_ir; ov = b_ov; ol = b_ol; on_ = b_on; bsy = b_bsy; idx = b_idx; end
         default: begin ir = c_ir; ov = c_ov; ol = c_ol; on_ = c_on; bsy = c_bsy; idx = {1'b0, c_idx}; end
      endcase
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0d expected %0d (sel=%0d t=%0t)", tag, got, exp, sel, $time);
      end
   endtask

   function automatic int cfg_width(input int s);
      return (s == 2) ? 5 : 16;
   endfunction

   function automatic bit cfg_msb(input int s);
      return (s != 1);
   endfunction

   // Expected beats: indices of set bits in priority order, or one "none" beat.
   task automatic model(input logic [15:0] v);
      int w;
      w = cfg_width(sel);
      exp_q.delete();
      exp_none = 1'b0;
      for (int k = 0; k < w; k++) begin
         int i;
         i = cfg_msb(sel) ? (w - 1 - k) : k;
         if (v[i]) exp_q.push_back(i);
      end
      if (exp_q.size() == 0) begin
         exp_q.push_back(0);
         exp_none = 1'b1;
      end
   endtask

   // Called at a negedge; returns at the negedge after the input handshake.
   task automatic send(input logic [15:0] v);
      int n;
      n = 0;
      while (!ir && n < 40) begin
         @(posedge clk); @(negedge clk); n++;
      end
      check("in_ready_wait", ir, 1);
      check("busy_idle", bsy, 0);
      check("valid_idle", ov, 0);
      model(v);
      iv = 1'b1;
      idata = v;
      @(posedge clk); @(negedge clk);
      iv = 1'b0;
      idata = 16'($urandom);
   endtask

   // mode 0: always ready, 1: toggle 1,0,1,0, 2: random.
   task automatic drain(input int mode);
      int n;
      bit r;
      n = 0;
      while (exp_q.size() > 0 && n < 200) begin
         check("valid", ov, 1);
         check("busy", bsy, 1);
         check("index", idx, exp_q[0]);
         check("last", ol, (exp_q.size() == 1) ? 1 : 0);
         check("none", on_, exp_none);
         if (mode == 0 || n > 100) r = 1'b1;
         else if (mode == 1) r = (n % 2 == 0);
         else r = 1'($urandom_range(0, 1));
         n++;
         ordy = r;
         iv = 1'($urandom_range(0, 1));
         @(posedge clk); @(negedge clk);
         ordy = 1'b0;
         iv = 1'b0;
         if (r) void'(exp_q.pop_front());
      end
      check("drain_done", exp_q.size(), 0);
      check("ready_after", ir, 1);
      check("valid_after", ov, 0);
   endtask

   initial begin
      logic [15:0] v;
      rst_n = 1'b0; iv = 1'b0; fl = 1'b0; ordy = 1'b0; idata = 16'h0000; sel = 0;
      #2;
      for (int s = 0; s < 3; s++) begin
         sel = s; #1;
         check("rst_ready", ir, 1); check("rst_valid", ov, 0); check("rst_busy", bsy, 0);
         check("rst_index", idx, 0); check("rst_last", ol, 0); check("rst_none", on_, 0);
      end
      sel = 0;
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Directed cases
      sel = 0; send(16'h8001); drain(0);
      sel = 0; send(16'h0000); drain(0);
      sel = 0; send(16'hFFFF); drain(1);
      sel = 1; send(16'h0120); drain(0);
      sel = 2; send(16'h0012); drain(2);

      // Flush after first beat: remaining beats dropped
      sel = 1; send(16'h00F0);
      check("flush_first", idx, 4);
      ordy = 1'b1; @(posedge clk); @(negedge clk);
      check("flush_second", idx, 5);
      fl = 1'b1; @(posedge clk); @(negedge clk);
      fl = 1'b0; ordy = 1'b0;
      check("flush_valid", ov, 0);
      check("flush_ready", ir, 1);
      @(posedge clk); @(negedge clk);
      check("flush_quiet", ov, 0);

      // Flush in IDLE blocks the input handshake
      iv = 1'b1; fl = 1'b1; idata = 16'h0F00;
      @(posedge clk); @(negedge clk);
      iv = 1'b0; fl = 1'b0;
      check("flush_idle_valid", ov, 0);
      check("flush_idle_ready", ir, 1);

      // Asynchronous reset mid-scan
      sel = 0; send(16'hFFFF);
      ordy = 1'b1; @(posedge clk); @(negedge clk); ordy = 1'b0;
      check("pre_rst_index", idx, 14);
      #2 rst_n = 1'b0; #1;
      check("arst_valid", ov, 0); check("arst_ready", ir, 1);
      check("arst_index", idx, 0); check("arst_last", ol, 0);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", ir, 1);
      send(16'h0004); drain(0);

      // Randomised vectors on each configuration
      for (int s = 0; s < 3; s++) begin
         sel = s;
         for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 3))
               0: v = 16'h0000;
               1: v = 16'($urandom) & 16'($urandom) & 16'($urandom);
               2: v = 16'h0001 << $urandom_range(0, 15);
               default: v = 16'($urandom);
            endcase
            if (s == 2) v = v & 16'h001F;
            send(v);
            drain(2);
         end
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
